muldiv_sched: RTL

Issue and completion controller for the multi-cycle multiplier and divider in the 5-stage pipeline. It accepts MUL/MULTU/DIV/DIVU issues from ID and pulses the matching unit's start. It tracks each unit's pending destination, raises the ID stall for RAW, HI/LO-ordering and structural hazards, and arbitrates the single EX writeback slot when results come back. It carries no operand or result data; the datapath uses `wb_src` to select the unit output.

---
 rtl/muldiv_sched_if.sv | 41 ++++
 rtl/muldiv_sched.sv | 133 +++++++++++++
 2 files changed

// File: rtl/muldiv_sched_if.sv
// ID-side issue/hazard signals, unit start/done handshakes and EX writeback slot
// shared between the pipeline and the mul/div scheduler.
interface muldiv_sched_if #(
    parameter int unsigned STALL_CNT_W = 16
);
    logic                   issue_valid;
    logic [1:0]             issue_op;
    logic [4:0]             issue_rd;
    logic [4:0]             id_rs;
    logic [4:0]             id_rt;
    logic                   id_use_rs;
    logic                   id_use_rt;
    logic                   id_use_hilo;
    logic                   stall;
    logic                   mult_start;
    logic                   mult_signed;
    logic                   mult_done;
    logic                   div_start;
    logic                   div_signed;
    logic                   div_done;
    logic                   wb_valid;
    logic                   wb_src;
    logic                   wb_gpr;
    logic                   wb_hilo;
    logic [4:0]             wb_rd;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output issue_valid, issue_op, issue_rd, id_rs, id_rt,
               id_use_rs, id_use_rt, id_use_hilo, mult_done, div_done,
        input  stall, mult_start, mult_signed, div_start, div_signed,
               wb_valid, wb_src, wb_gpr, wb_hilo, wb_rd, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_op, issue_rd, id_rs, id_rt,
               id_use_rs, id_use_rt, id_use_hilo, mult_done, div_done,
        output stall, mult_start, mult_signed, div_start, div_signed,
               wb_valid, wb_src, wb_gpr, wb_hilo, wb_rd, stall_cycles
    );
endinterface

// File: rtl/muldiv_sched.sv
// Issue/completion controller for the multi-cycle multiplier and divider:
// hazard stall generation, unit start pulses and single-slot writeback arbitration.
module muldiv_sched #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    muldiv_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } unit_st_t;

    unit_st_t               r_m_st, r_d_st, w_m_st_nxt, w_d_st_nxt;
    logic [4:0]             r_m_rd, r_d_rd, w_new_rd;
    logic                   r_m_gpr, r_d_gpr, r_m_hilo, r_d_hilo;
    logic                   r_m_older;
    logic                   r_wb_valid, r_wb_src, r_wb_gpr, r_wb_hilo;
    logic [4:0]             r_wb_rd;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_m_pend, w_d_pend, w_is_div, w_new_gpr, w_new_hilo;
    logic w_raw_rs, w_raw_rt, w_hilo_rd, w_struct, w_order, w_stall;
    logic w_accept, w_m_start, w_d_start;
    logic w_m_cand, w_d_cand, w_gnt_m, w_gnt_d;

    function automatic unit_st_t f_next(unit_st_t st, logic start, logic done, logic gnt);
        unit_st_t nxt;
        nxt = st;
        case (st)
            ST_IDLE: nxt = start ? ST_BUSY : ST_IDLE;
            ST_BUSY: nxt = done ? (gnt ? ST_IDLE : ST_DONE) : ST_BUSY;
            ST_DONE: nxt = gnt ? ST_IDLE : ST_DONE;
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    always_comb begin
        w_m_pend   = (r_m_st != ST_IDLE);
        w_d_pend   = (r_d_st != ST_IDLE);
        w_is_div   = bus.issue_op[1];
        w_new_gpr  = (bus.issue_op == 2'b00);
        w_new_hilo = !w_new_gpr;
        w_new_rd   = w_new_gpr ? bus.issue_rd : '0;

        w_raw_rs  = bus.id_use_rs && (bus.id_rs != '0) &&
                    ((w_m_pend && r_m_gpr && bus.id_rs == r_m_rd) ||
                     (w_d_pend && r_d_gpr && bus.id_rs == r_d_rd));
        w_raw_rt  = bus.id_use_rt && (bus.id_rt != '0) &&
                    ((w_m_pend && r_m_gpr && bus.id_rt == r_m_rd) ||
                     (w_d_pend && r_d_gpr && bus.id_rt == r_d_rd));
        w_hilo_rd = bus.id_use_hilo && ((w_m_pend && r_m_hilo) || (w_d_pend && r_d_hilo));
        w_struct  = bus.issue_valid && (w_is_div ? w_d_pend : w_m_pend);
        w_order   = bus.issue_valid && w_new_hilo &&
                    (w_is_div ? (w_m_pend && r_m_hilo) : (w_d_pend && r_d_hilo));

        // Gated by reset so the combinational outputs read 0 while reset is held.
        w_stall   = !reset && (w_raw_rs || w_raw_rt || w_hilo_rd || w_struct ||
                               w_order || r_wb_valid);
        w_accept  = !reset && bus.issue_valid && !w_stall;
        w_m_start = w_accept && !w_is_div;
        w_d_start = w_accept && w_is_div;

        // A unit already parked in DONE outranks a fresh done; otherwise the older issue wins.
        w_m_cand = (r_m_st == ST_DONE) || (r_m_st == ST_BUSY && bus.mult_done);
        w_d_cand = (r_d_st == ST_DONE) || (r_d_st == ST_BUSY && bus.div_done);
        w_gnt_m  = w_m_cand && (!w_d_cand ||
                   (((r_m_st == ST_DONE) != (r_d_st == ST_DONE)) ? (r_m_st == ST_DONE)
                                                                 : r_m_older));
        w_gnt_d  = w_d_cand && !w_gnt_m;

        w_m_st_nxt = f_next(r_m_st, w_m_start, bus.mult_done, w_gnt_m);
        w_d_st_nxt = f_next(r_d_st, w_d_start, bus.div_done, w_gnt_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_st      <= ST_IDLE;
            r_d_st      <= ST_IDLE;
            r_m_rd      <= '0;
            r_d_rd      <= '0;
            r_m_gpr     <= 1'b0;
            r_d_gpr     <= 1'b0;
            r_m_hilo    <= 1'b0;
            r_d_hilo    <= 1'b0;
            r_m_older   <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_src    <= 1'b0;
            r_wb_gpr    <= 1'b0;
            r_wb_hilo   <= 1'b0;
            r_wb_rd     <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_m_st <= w_m_st_nxt;
            r_d_st <= w_d_st_nxt;
            if (w_m_start) begin
                r_m_rd    <= w_new_rd;
                r_m_gpr   <= w_new_gpr;
                r_m_hilo  <= w_new_hilo;
                r_m_older <= !w_d_pend;
            end
            if (w_d_start) begin
                r_d_rd    <= w_new_rd;
                r_d_gpr   <= w_new_gpr;
                r_d_hilo  <= w_new_hilo;
                r_m_older <= w_m_pend;
            end
            r_wb_valid <= w_gnt_m || w_gnt_d;
            r_wb_src   <= w_gnt_d;
            r_wb_gpr   <= (w_gnt_m && r_m_gpr) || (w_gnt_d && r_d_gpr);
            r_wb_hilo  <= (w_gnt_m && r_m_hilo) || (w_gnt_d && r_d_hilo);
            r_wb_rd    <= w_gnt_m ? r_m_rd : (w_gnt_d ? r_d_rd : '0);
            if (w_stall && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.mult_start   = w_m_start;
    assign bus.mult_signed  = w_m_start && !bus.issue_op[0];
    assign bus.div_start    = w_d_start;
    assign bus.div_signed   = w_d_start && !bus.issue_op[0];
    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_src       = r_wb_src;
    assign bus.wb_gpr       = r_wb_gpr;
    assign bus.wb_hilo      = r_wb_hilo;
    assign bus.wb_rd        = r_wb_rd;
    assign bus.stall_cycles = r_stall_cnt;
endmodule
